// File: rtl/jk_conv_pkg.sv
// jk_conv_pkg: shared types and the JK-conversion helper for jk_conv_ctrl.
//   mode_e  : command mode encodings (JK / SR / D / T)
//   state_e : controller FSM states
//   jk_conv : returns {J,K} for one bit given mode and operand pair
// Optional feature macro: JK_CONV_SR_CHECK_EN. When it is defined, SR bits
// with S=R=1 are neutralised to J=K=0. When it is not defined, those bits
// are driven J=K=1 and toggle.
package jk_conv_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    APPLY = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Returns {J,K} for a single cell.
  function automatic logic [1:0] jk_conv(input mode_e m, input logic a, input logic b);
    logic [1:0] jk;
    jk = 2'b00;
    case (m)
      MODE_JK: jk = {a, b};
      MODE_SR: begin
`ifdef JK_CONV_SR_CHECK_EN
        // S=R=1 is illegal for an SR cell; hold the bit instead.
        if (a && b) jk = 2'b00;
        else        jk = {a & ~b, b & ~a};
`else
        // S=R=1 falls through to the JK toggle case.
        if (a && b) jk = 2'b11;
        else        jk = {a & ~b, b & ~a};
`endif
      end
      MODE_D:  jk = {a, ~a};
      MODE_T:  jk = {a, a};
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop storage cell with clock enable.
//   clk, rst_n : clock, asynchronous active-low reset (clears q)
//   en         : update enable; q holds when low
//   j, k       : 00 hold, 01 clear, 10 set, 11 toggle
//   q          : cell state
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_conv_ctrl.sv
// jk_conv_ctrl: sequencing controller for a WIDTH-bit bank of JK cells.
// Accepts a command (mode, operands, repeat count) on a valid/ready
// handshake, converts operands to per-bit J/K drive, then enables the bank
// for cmd_cnt+1 consecutive edges and pulses done.
//   clk, rst_n         : clock, asynchronous active-low reset
//   cmd_valid/ready    : command handshake; ready only in IDLE
//   cmd_mode           : 00 JK, 01 SR, 10 D, 11 T
//   cmd_a, cmd_b       : J/S/D/T and K/R operands
//   cmd_cnt            : extra update edges (total = cmd_cnt+1)
//   busy               : high in APPLY and DONE
//   done               : one-cycle pulse after the last update edge
//   err                : illegal-SR flag, held until next acceptance
//   q                  : bank state
// Optional feature macro: JK_CONV_SR_CHECK_EN (SR S=R=1 detection; err is
// tied low when undefined).
module jk_conv_ctrl
  import jk_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] q
);

  state_e           state;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] j_r, k_r;
  logic [WIDTH-1:0] j_n, k_n;
  logic             accept;
  logic             en;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == APPLY) || (state == DONE);
  assign done      = (state == DONE);
  assign en        = (state == APPLY);
  assign accept    = cmd_valid && cmd_ready;

  // Per-bit conversion of the incoming command; only sampled on accept.
  always_comb begin
    j_n = '0;
    k_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j_n[i], k_n[i]} = jk_conv(mode_e'(cmd_mode), cmd_a[i], cmd_b[i]);
    end
  end

  // rem counts the edges still owed after the current one, so APPLY lasts
  // cmd_cnt+1 cycles and the all-ones count never needs an extra bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      j_r   <= '0;
      k_r   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          j_r   <= j_n;
          k_r   <= k_n;
          rem   <= cmd_cnt;
          state <= APPLY;
        end
        APPLY: begin
          if (rem == '0) state <= DONE;
          else           rem   <= rem - CNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_CONV_SR_CHECK_EN
  logic err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_r <= 1'b0;
    else if (accept) err_r <= (mode_e'(cmd_mode) == MODE_SR) && |(cmd_a & cmd_b);
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .j     (j_r[g]),
      .k     (k_r[g]),
      .q     (q[g])
    );
  end

endmodule
